// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: counter/colour widths, text-grid geometry
// and the packed timing+colour bundle carried through delay lines.
// No ports; imported by the text-overlay stages.
package vga_pkg;

  localparam int COUNT_W           = 11;
  localparam int RGB_W             = 12;

  localparam int CHAR_W            = 8;
  localparam int CHAR_H            = 16;
  localparam int TEXT_COLS         = 16;
  localparam int TEXT_ROWS         = 16;
  localparam int DRAW_CHAR_LATENCY = 4;

  // Pixel extent of the text rectangle.
  localparam int RECT_W = CHAR_W * TEXT_COLS;   // 128
  localparam int RECT_H = CHAR_H * TEXT_ROWS;   // 256

  // Timing + colour stream as one packed word so it can share a delay line.
  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic [RGB_W-1:0]   rgb;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);   // 38

endpackage

// File: rtl/signal_delay.sv
// Generic WIDTH x DEPTH register chain; dout is din delayed by DEPTH cycles.
// Ports: clk, rst_n (async active-low, clears every stage), din, dout.
// Latency DEPTH cycles, no flow control.
module signal_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/draw_rect_char_16x16.sv
// Text overlay for a 128x256 px rectangle of 16x16 8x16-pixel characters.
// Ports: VGA stream in (hcount/vcount/sync/blank/rgb), text ROM address
//   char_xy, font line char_line, font row char_pixels, VGA stream out.
// Latency 4 cycles on every *_out; no back-pressure.
// Optional macro DRAW_RECT_CHAR_BG_EN: fill empty glyph pixels with BG_COLOR.
module draw_rect_char_16x16
  import vga_pkg::*;
#(
  parameter int               XPOS       = 100,
  parameter int               YPOS       = 100,
  parameter logic [RGB_W-1:0] TEXT_COLOR = 12'hfff,
  parameter logic [RGB_W-1:0] BG_COLOR   = 12'h000
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic [COUNT_W-1:0] hcount_in,
  input  logic [COUNT_W-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,

  output logic [7:0]         char_xy,
  output logic [3:0]         char_line,
  input  logic [7:0]         char_pixels,

  output logic [COUNT_W-1:0] hcount_out,
  output logic [COUNT_W-1:0] vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam logic [COUNT_W-1:0] X_LO = COUNT_W'(XPOS);
  localparam logic [COUNT_W-1:0] X_HI = COUNT_W'(XPOS + RECT_W);
  localparam logic [COUNT_W-1:0] Y_LO = COUNT_W'(YPOS);
  localparam logic [COUNT_W-1:0] Y_HI = COUNT_W'(YPOS + RECT_H);

  // ---------------- stage 0: rectangle test and cell offsets -------------
  logic       in_rect;
  logic [6:0] dx;   // only the low bits of the offset are ever needed, so
  logic [7:0] dy;   // subtracting on the truncated operands is equivalent

  assign in_rect = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                   (vcount_in >= Y_LO) && (vcount_in < Y_HI) &&
                   !(hblnk_in || vblnk_in);
  assign dx = hcount_in[6:0] - X_LO[6:0];
  assign dy = vcount_in[7:0] - Y_LO[7:0];

  // ---------------- stage 1: text ROM address ----------------------------
  logic [3:0] line_s1;
  logic [2:0] gx_s1;
  logic       in_rect_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy    <= '0;
      line_s1    <= '0;
      gx_s1      <= '0;
      in_rect_s1 <= 1'b0;
    end else begin
      char_xy    <= in_rect ? {dy[7:4], dx[6:3]} : 8'h00;
      line_s1    <= in_rect ? dy[3:0] : 4'h0;
      gx_s1      <= dx[2:0];
      in_rect_s1 <= in_rect;
    end
  end

  // ---------------- stage 2: glyph line, aligned with char_code ----------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_line <= '0;
    else        char_line <= line_s1;
  end

  // glyph x / in_rect ride along to stage 3, where char_pixels arrives.
  logic [2:0] gx_s3;
  logic       in_rect_s3;

  signal_delay #(.WIDTH(4), .DEPTH(2)) u_glyph_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({in_rect_s1, gx_s1}),
    .dout  ({in_rect_s3, gx_s3})
  );

  // ---------------- stage 4: pixel decision ------------------------------
  // Registered alongside the last stage of the bus delay line so that the
  // colour mux below sees both at the same cycle.
  logic pix_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pix_q <= 1'b0;
    else        pix_q <= in_rect_s3 && char_pixels[3'd7 - gx_s3];
  end

`ifdef DRAW_RECT_CHAR_BG_EN
  logic in_rect_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_rect_q <= 1'b0;
    else        in_rect_q <= in_rect_s3;
  end
`endif

  // ---------------- timing + colour bundle -------------------------------
  vga_bus_t bus_in;
  vga_bus_t bus_d;

  assign bus_in = '{hsync:  hsync_in,  vsync:  vsync_in,
                    hblnk:  hblnk_in,  vblnk:  vblnk_in,
                    hcount: hcount_in, vcount: vcount_in,
                    rgb:    rgb_in};

  signal_delay #(.WIDTH(VGA_BUS_W), .DEPTH(DRAW_CHAR_LATENCY)) u_bus_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus_in),
    .dout  (bus_d)
  );

  assign hcount_out = bus_d.hcount;
  assign vcount_out = bus_d.vcount;
  assign hsync_out  = bus_d.hsync;
  assign vsync_out  = bus_d.vsync;
  assign hblnk_out  = bus_d.hblnk;
  assign vblnk_out  = bus_d.vblnk;

  // Blanking is already folded into in_rect, so blank pixels never take
  // the text or fill colour.
  always_comb begin
    rgb_out = bus_d.rgb;
    if (pix_q) begin
      rgb_out = TEXT_COLOR;
    end
`ifdef DRAW_RECT_CHAR_BG_EN
    else if (in_rect_q) begin
      rgb_out = BG_COLOR;
    end
`endif
  end

endmodule

// File: tb/tb_draw_rect_char_16x16.sv
module tb_draw_rect_char_16x16;

  localparam int XPOS = 100;
  localparam int YPOS = 100;
  localparam logic [11:0] TEXT_COLOR = 12'hfff;
  localparam logic [11:0] BG_COLOR   = 12'h00f;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } px_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;

  draw_rect_char_16x16 #(
    .XPOS(XPOS), .YPOS(YPOS), .TEXT_COLOR(TEXT_COLOR), .BG_COLOR(BG_COLOR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .char_xy(char_xy), .char_line(char_line), .char_pixels(char_pixels),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Behavioural registered ROMs: text (char_xy -> code), font ({code,line} -> row).
  logic [7:0] text_mem [256];
  logic [7:0] font_mem [4096];
  logic [7:0] char_code = '0;

  always @(posedge clk) begin
    char_code   <= text_mem[char_xy];
    char_pixels <= font_mem[{char_code, char_line}];
  end

  // ---------------- reference model ---------------------------------------
  function automatic bit inr(input px_t p);
    return (int'(p.h) >= XPOS) && (int'(p.h) < XPOS + 128) &&
           (int'(p.v) >= YPOS) && (int'(p.v) < YPOS + 256) && !p.hb && !p.vb;
  endfunction

  function automatic logic [7:0] exp_xy(input px_t p);
    int dx, dy;
    dx = int'(p.h) - XPOS;
    dy = int'(p.v) - YPOS;
    if (!inr(p)) return 8'h00;
    return 8'((dy / 16) * 16 + dx / 8);
  endfunction

  function automatic logic [3:0] exp_line(input px_t p);
    if (!inr(p)) return 4'h0;
    return 4'((int'(p.v) - YPOS) % 16);
  endfunction

  function automatic logic [11:0] exp_rgb(input px_t p);
    int dx, dy, code;
    logic [7:0] bits;
    if (!inr(p)) return p.rgb;
    dx   = int'(p.h) - XPOS;
    dy   = int'(p.v) - YPOS;
    code = int'(text_mem[(dy / 16) * 16 + dx / 8]);
    bits = font_mem[code * 16 + dy % 16];
    if (bits[7 - dx % 8]) return TEXT_COLOR;
`ifdef DRAW_RECT_CHAR_BG_EN
    return BG_COLOR;
`else
    return p.rgb;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (h=%0d v=%0d t=%0t)", tag, got, exp,
               hcount_out, vcount_out, $time);
    end
  endtask

  // hist[0] = input of the most recent edge, hist[k] = k edges earlier.
  px_t hist [$];

  task automatic drive(input px_t p);
    hcount_in = p.h;  vcount_in = p.v;
    hsync_in  = p.hs; vsync_in  = p.vs;
    hblnk_in  = p.hb; vblnk_in  = p.vb;
    rgb_in    = p.rgb;
    hist.push_front(p);
    if (hist.size() > 5) hist.delete(5);
  endtask

  task automatic check_all();
    px_t p3;
    p3 = hist[3];
    chk("char_xy",   32'(char_xy),    32'(exp_xy(hist[0])));
    chk("char_line", 32'(char_line),  32'(exp_line(hist[1])));
    chk("rgb_out",   32'(rgb_out),    32'(exp_rgb(p3)));
    chk("hcount",    32'(hcount_out), 32'(p3.h));
    chk("vcount",    32'(vcount_out), 32'(p3.v));
    chk("hsync",     32'(hsync_out),  32'(p3.hs));
    chk("vsync",     32'(vsync_out),  32'(p3.vs));
    chk("hblnk",     32'(hblnk_out),  32'(p3.hb));
    chk("vblnk",     32'(vblnk_out),  32'(p3.vb));
    // Directed corner points with fixed expectations.
    if (hist[0].h == 11'(XPOS) && hist[0].v == 11'(YPOS) && !hist[0].hb && !hist[0].vb)
      chk("a_xy", 32'(char_xy), 32'h00);
    if (hist[1].h == 11'(XPOS) && hist[1].v == 11'(YPOS) && !hist[1].hb && !hist[1].vb)
      chk("a_line", 32'(char_line), 32'h0);
    if (p3.h == 11'(XPOS) && p3.v == 11'(YPOS) && !p3.hb && !p3.vb)
      chk("a_rgb", 32'(rgb_out), 32'hfff);
    if (hist[0].h == 11'(XPOS + 127) && hist[0].v == 11'(YPOS + 255) && !hist[0].hb)
      chk("corner_xy", 32'(char_xy), 32'hff);
    if (hist[1].h == 11'(XPOS + 127) && hist[1].v == 11'(YPOS + 255) && !hist[1].hb)
      chk("corner_line", 32'(char_line), 32'd15);
    if (hist[0].h == 11'(XPOS + 128) && hist[0].v == 11'(YPOS))
      chk("outside_xy", 32'(char_xy), 32'h00);
    if (p3.h == 11'(XPOS + 128) && p3.v == 11'(YPOS))
      chk("outside_rgb", 32'(rgb_out), 32'h0a5);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_xy"},   32'(char_xy),    0);
    chk({tag, "_line"}, 32'(char_line),  0);
    chk({tag, "_rgb"},  32'(rgb_out),    0);
    chk({tag, "_h"},    32'(hcount_out), 0);
    chk({tag, "_v"},    32'(vcount_out), 0);
    chk({tag, "_sync"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 0);
  endtask

  initial begin : main
    int lines [12] = '{0, 99, 100, 101, 115, 116, 200, 355, 356, 479, 480, 490};
    px_t p;
    bit  release_pending;

    release_pending = 1'b0;
    for (int i = 0; i < 256; i++)  text_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
    text_mem[0]       = 8'h61;   // 'a'
    font_mem[97 * 16] = 8'h80;   // row 0 of 'a': leftmost pixel only

    for (int i = 0; i < 5; i++) hist.push_front('0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 check_zero("reset");

    @(negedge clk);
    rst_n = 1'b1;

    // Line sweep through a 800x525 frame, visiting lines around all edges.
    foreach (lines[li]) begin
      for (int h = 0; h < 800; h++) begin
        @(negedge clk);
        if (release_pending) begin
          rst_n = 1'b1;
          release_pending = 1'b0;
          for (int k = 0; k < 5; k++) hist[k] = '0;
        end
        p.h   = 11'(h);
        p.v   = 11'(lines[li]);
        p.hb  = (h >= 640);
        p.hs  = (h >= 656) && (h < 752);
        p.vb  = (lines[li] >= 480);
        p.vs  = (lines[li] >= 490) && (lines[li] < 492);
        p.rgb = 12'($urandom) | 12'h001;
        if (h == XPOS + 128 && lines[li] == YPOS) p.rgb = 12'h0a5;
        drive(p);
        @(posedge clk);
        #1 check_all();
        if (lines[li] == 116 && h == 300) begin
          #2 rst_n = 1'b0;
          #1 check_zero("arst");
          release_pending = 1'b1;
        end
      end
    end

    // Random pixels biased around the rectangle, with random blanking.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      p.h   = 11'($urandom_range(90, 240));
      p.v   = 11'($urandom_range(90, 370));
      p.hb  = ($urandom_range(0, 5) == 0);
      p.vb  = ($urandom_range(0, 7) == 0);
      p.hs  = 1'($urandom);
      p.vs  = 1'($urandom);
      p.rgb = 12'($urandom);
      drive(p);
      @(posedge clk);
      #1 check_all();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
